poke_select_ctrl: RTL

//  Cursor/selection controller upstream of the pokemon choose-scene pixel mux.

---
 rtl/poke_sel_pkg.sv | 24 ++
 rtl/poke_select_ctrl_if.sv | 28 ++
 rtl/blink_timer.sv | 41 ++++
 rtl/poke_select_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/poke_sel_pkg.sv
// Shared types and constants for the pokemon choose-scene selection controller.
package poke_sel_pkg;

    // Controller states; the encoding is fixed so scene logic can decode it.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BROWSE  = 2'd1,
        ST_CONFIRM = 2'd2
    } poke_state_e;

    localparam int unsigned POKE_GRID_COLS = 4;
    localparam int unsigned POKE_GRID_ROWS = 2;

    // Id value meaning "no tile": shown while idle and before any confirm.
    localparam logic [7:0] POKE_NONE = 8'd0;

    // Row-major tile id, 1-based so that 0 stays free for POKE_NONE.
    function automatic logic [7:0] tile_id(input logic [7:0] row,
                                           input logic [7:0] col,
                                           input int unsigned cols);
        return 8'(int'(row) * int'(cols) + int'(col) + 1);
    endfunction

endpackage

// File: rtl/poke_select_ctrl_if.sv
// Button/level inputs and id/blink outputs of the selection controller.
interface poke_select_ctrl_if;

    logic       scene_en;
    logic       btn_left;
    logic       btn_right;
    logic       btn_up;
    logic       btn_down;
    logic       btn_enter;
    logic       btn_back;
    logic [7:0] pokemon_id;
    logic       cursor_vis;
    logic [7:0] selected_id;
    logic       select_done;

    // Button source / scene side.
    modport master (
        output scene_en, btn_left, btn_right, btn_up, btn_down, btn_enter, btn_back,
        input  pokemon_id, cursor_vis, selected_id, select_done
    );

    // The controller itself.
    modport slave (
        input  scene_en, btn_left, btn_right, btn_up, btn_down, btn_enter, btn_back,
        output pokemon_id, cursor_vis, selected_id, select_done
    );

endinterface

// File: rtl/blink_timer.sv
// Free-running half-period counter for the cursor blink.
// wrap is high while the count sits at HALF-1; the parent toggles on it.
module blink_timer #(
    parameter int unsigned HALF = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam int unsigned W = (HALF > 2) ? $clog2(HALF) : 1;
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign wrap = (count_q == LAST);

    // Clear wins over counting; counting restarts from 0 after the last value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/poke_select_ctrl.sv
// Cursor/selection controller for the pokemon choose scene.
// Converts one-cycle button pulses into a cursor over the tile grid, blinks the
// highlight frame while browsing and latches the confirmed tile id.
// Build option: define POKE_SEL_WRAP_EN to wrap the cursor at the grid edges;
// without it the cursor saturates and an edge push counts as no move.
module poke_select_ctrl
    import poke_sel_pkg::*;
#(
    parameter int unsigned GRID_COLS  = POKE_GRID_COLS,
    parameter int unsigned GRID_ROWS  = POKE_GRID_ROWS,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input logic               clk,
    input logic               rst_n,
    poke_select_ctrl_if.slave bus
);

    localparam logic [7:0] LAST_COL = 8'(GRID_COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(GRID_ROWS - 1);

    poke_state_e state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [7:0]  col_q, col_d;
    logic [7:0]  pokemon_id_q, pokemon_id_d;
    logic [7:0]  selected_id_q, selected_id_d;
    logic        cursor_vis_q, cursor_vis_d;
    logic        select_done_q, select_done_d;

    logic        blink_en;
    logic        blink_clr;
    logic        blink_wrap;

    logic        h_left, h_right, v_up, v_down;
    logic [7:0]  row_mv, col_mv;
    logic        moved;

    blink_timer #(
        .HALF (BLINK_HALF)
    ) u_blink (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (blink_en),
        .clr   (blink_clr),
        .wrap  (blink_wrap)
    );

    // Candidate cursor position; opposite buttons on one axis cancel out.
    always_comb begin
        h_left  = bus.btn_left  & ~bus.btn_right;
        h_right = bus.btn_right & ~bus.btn_left;
        v_up    = bus.btn_up    & ~bus.btn_down;
        v_down  = bus.btn_down  & ~bus.btn_up;
        col_mv  = col_q;
        row_mv  = row_q;
`ifdef POKE_SEL_WRAP_EN
        if (h_right) col_mv = (col_q == LAST_COL) ? 8'd0 : col_q + 8'd1;
        if (h_left)  col_mv = (col_q == 8'd0) ? LAST_COL : col_q - 8'd1;
        if (v_down)  row_mv = (row_q == LAST_ROW) ? 8'd0 : row_q + 8'd1;
        if (v_up)    row_mv = (row_q == 8'd0) ? LAST_ROW : row_q - 8'd1;
`else
        if (h_right && col_q != LAST_COL) col_mv = col_q + 8'd1;
        if (h_left  && col_q != 8'd0)     col_mv = col_q - 8'd1;
        if (v_down  && row_q != LAST_ROW) row_mv = row_q + 8'd1;
        if (v_up    && row_q != 8'd0)     row_mv = row_q - 8'd1;
`endif
        // A push that leaves the cursor in place is not a move.
        moved = (col_mv != col_q) || (row_mv != row_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; dropping scene_en returns to IDLE from anywhere.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!bus.scene_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_d = ST_BROWSE;
                ST_BROWSE:  if (bus.btn_enter) state_d = ST_CONFIRM;
                ST_CONFIRM: if (bus.btn_back && !bus.btn_enter) state_d = ST_BROWSE;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    // Next values of cursor, blink and selection registers.
    always_comb begin
        row_d         = row_q;
        col_d         = col_q;
        selected_id_d = selected_id_q;
        select_done_d = 1'b0;
        cursor_vis_d  = cursor_vis_q;
        blink_en      = 1'b0;
        blink_clr     = 1'b1;
        if (!bus.scene_en) begin
            cursor_vis_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Each entry into the scene starts on tile 1, frame visible.
                    row_d        = 8'd0;
                    col_d        = 8'd0;
                    cursor_vis_d = 1'b1;
                end
                ST_BROWSE: begin
                    if (bus.btn_enter) begin
                        selected_id_d = tile_id(row_q, col_q, GRID_COLS);
                        select_done_d = 1'b1;
                        cursor_vis_d  = 1'b1;
                    end else if (!bus.btn_back && moved) begin
                        row_d        = row_mv;
                        col_d        = col_mv;
                        cursor_vis_d = 1'b1;
                    end else begin
                        blink_en  = 1'b1;
                        blink_clr = 1'b0;
                        if (blink_wrap) cursor_vis_d = ~cursor_vis_q;
                    end
                end
                ST_CONFIRM: begin
                    cursor_vis_d = 1'b1;
                end
                default: begin
                    cursor_vis_d = 1'b0;
                end
            endcase
        end
        pokemon_id_d = (state_d == ST_IDLE) ? POKE_NONE : tile_id(row_d, col_d, GRID_COLS);
    end

    // Output and cursor registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q         <= 8'd0;
            col_q         <= 8'd0;
            pokemon_id_q  <= POKE_NONE;
            selected_id_q <= POKE_NONE;
            cursor_vis_q  <= 1'b0;
            select_done_q <= 1'b0;
        end else begin
            row_q         <= row_d;
            col_q         <= col_d;
            pokemon_id_q  <= pokemon_id_d;
            selected_id_q <= selected_id_d;
            cursor_vis_q  <= cursor_vis_d;
            select_done_q <= select_done_d;
        end
    end

    assign bus.pokemon_id  = pokemon_id_q;
    assign bus.selected_id = selected_id_q;
    assign bus.cursor_vis  = cursor_vis_q;
    assign bus.select_done = select_done_q;

endmodule
